// File: rtl/zmod_spi_arbiter.sv
// -----------------------------------------------------------------------------
// zmod_spi_arbiter
//
// Shares one 3-wire SPI configuration engine between the ADC1410 and DAC1411
// init sequencers. Each side issues single register read/write transactions
// over a level req / one-cycle ack handshake. Ties are broken round-robin.
// Exactly one command is forwarded per grant. Read data, or a timeout error,
// is returned to the winning requester.
//
// Ports:
//   i_clock, i_reset          system clock, synchronous active-high reset
//   i_adc_req/rnw/addr/wdata  ADC command (held until o_adc_ack)
//   o_adc_ack/rdata/err       ADC completion pulse, read data, timeout flag
//   i_dac_* / o_dac_*         same for the DAC requester
//   o_spi_start               one-cycle command strobe to the SPI engine
//   o_spi_rnw/addr/wdata      latched command, stable until the next grant
//   i_spi_done, i_spi_rdata   end-of-transfer strobe and read data
//   o_grant                   bit0 = ADC owns the engine, bit1 = DAC
//   o_busy                    high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module zmod_spi_arbiter #(
   parameter int ADDR_SIZE      = 13,
   parameter int DATA_SIZE      = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_adc_req,
   input  logic                 i_adc_rnw,
   input  logic [ADDR_SIZE-1:0] i_adc_addr,
   input  logic [DATA_SIZE-1:0] i_adc_wdata,
   output logic                 o_adc_ack,
   output logic [DATA_SIZE-1:0] o_adc_rdata,
   output logic                 o_adc_err,
   input  logic                 i_dac_req,
   input  logic                 i_dac_rnw,
   input  logic [ADDR_SIZE-1:0] i_dac_addr,
   input  logic [DATA_SIZE-1:0] i_dac_wdata,
   output logic                 o_dac_ack,
   output logic [DATA_SIZE-1:0] o_dac_rdata,
   output logic                 o_dac_err,
   output logic                 o_spi_start,
   output logic                 o_spi_rnw,
   output logic [ADDR_SIZE-1:0] o_spi_addr,
   output logic [DATA_SIZE-1:0] o_spi_wdata,
   input  logic                 i_spi_done,
   input  logic [DATA_SIZE-1:0] i_spi_rdata,
   output logic [1:0]           o_grant,
   output logic                 o_busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                 state;
   logic                   last_dac;   // 1 = DAC was served last
   logic [CNT_W-1:0]       wait_cnt;
   logic [1:0]             win;
   logic [DATA_SIZE-1:0]   resp_rdata;
   logic                   resp_err;

   // One-hot winner, or zero when nobody requests. On a tie the side that
   // was not served last wins.
   function automatic logic [1:0] pick_winner(input logic adc_req,
                                              input logic dac_req,
                                              input logic dac_was_last);
      if (adc_req && dac_req)
         return dac_was_last ? 2'b01 : 2'b10;
      return {dac_req, adc_req};
   endfunction

   assign win = pick_winner(i_adc_req, i_dac_req, last_dac);

   // A done strobe always beats a timeout in the same cycle; writes return 0.
   assign resp_rdata = (i_spi_done && o_spi_rnw) ? i_spi_rdata : '0;
   assign resp_err   = ~i_spi_done;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= ST_IDLE;
         last_dac    <= 1'b1;
         wait_cnt    <= '0;
         o_adc_ack   <= 1'b0;
         o_adc_rdata <= '0;
         o_adc_err   <= 1'b0;
         o_dac_ack   <= 1'b0;
         o_dac_rdata <= '0;
         o_dac_err   <= 1'b0;
         o_spi_start <= 1'b0;
         o_spi_rnw   <= 1'b0;
         o_spi_addr  <= '0;
         o_spi_wdata <= '0;
         o_grant     <= 2'b00;
         o_busy      <= 1'b0;
      end else begin
         case (state)
            // IDLE -> ISSUE: latch the winner's command, strobe start next cycle
            ST_IDLE: begin
               if (win != 2'b00) begin
                  o_grant     <= win;
                  o_spi_rnw   <= win[0] ? i_adc_rnw   : i_dac_rnw;
                  o_spi_addr  <= win[0] ? i_adc_addr  : i_dac_addr;
                  o_spi_wdata <= win[0] ? i_adc_wdata : i_dac_wdata;
                  o_spi_start <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            // ISSUE -> WAIT: start is high for this single cycle
            ST_ISSUE: begin
               o_spi_start <= 1'b0;
               wait_cnt    <= '0;
               state       <= ST_WAIT;
            end
            // WAIT -> RESP: on done or after TIMEOUT_CYCLES wait cycles
            ST_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (i_spi_done || (wait_cnt == CNT_LAST)) begin
                  if (o_grant[0]) begin
                     o_adc_ack   <= 1'b1;
                     o_adc_rdata <= resp_rdata;
                     o_adc_err   <= resp_err;
                  end
                  if (o_grant[1]) begin
                     o_dac_ack   <= 1'b1;
                     o_dac_rdata <= resp_rdata;
                     o_dac_err   <= resp_err;
                  end
                  state <= ST_RESP;
               end
            end
            // RESP -> IDLE: ack visible this cycle only
            ST_RESP: begin
               o_adc_ack <= 1'b0;
               o_dac_ack <= 1'b0;
               last_dac  <= o_grant[1];
               o_grant   <= 2'b00;
               o_busy    <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zmod_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zmod_spi_arbiter
//
// Directed bench for zmod_spi_arbiter with TIMEOUT_CYCLES = 16. The stimulus
// thread pushes the expected SPI command and the expected completion into two
// queues. An independent monitor compares them against o_spi_start and the ack
// pulses on the falling edge.
// -----------------------------------------------------------------------------
module tb_zmod_spi_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          adc_req, adc_rnw, dac_req, dac_rnw;
   logic [AW-1:0] adc_addr, dac_addr;
   logic [DW-1:0] adc_wdata, dac_wdata;
   logic          adc_ack, adc_err, dac_ack, dac_err;
   logic [DW-1:0] adc_rdata, dac_rdata;
   logic          spi_start, spi_rnw, spi_done;
   logic [AW-1:0] spi_addr;
   logic [DW-1:0] spi_wdata, spi_rdata;
   logic [1:0]    grant;
   logic          busy;

   always #5 clk = ~clk;

   zmod_spi_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_adc_req(adc_req), .i_adc_rnw(adc_rnw), .i_adc_addr(adc_addr),
      .i_adc_wdata(adc_wdata), .o_adc_ack(adc_ack), .o_adc_rdata(adc_rdata),
      .o_adc_err(adc_err),
      .i_dac_req(dac_req), .i_dac_rnw(dac_rnw), .i_dac_addr(dac_addr),
      .i_dac_wdata(dac_wdata), .o_dac_ack(dac_ack), .o_dac_rdata(dac_rdata),
      .o_dac_err(dac_err),
      .o_spi_start(spi_start), .o_spi_rnw(spi_rnw), .o_spi_addr(spi_addr),
      .o_spi_wdata(spi_wdata), .i_spi_done(spi_done), .i_spi_rdata(spi_rdata),
      .o_grant(grant), .o_busy(busy)
   );

   typedef struct packed {
      logic [1:0]    who;
      logic          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [1:0]    who;
      logic [DW-1:0] rdata;
      logic          err;
   } ack_t;

   cmd_t cmd_q[$];
   ack_t ack_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Monitor: compares every start and every ack against the queues.
   initial begin : monitor
      cmd_t       cur;
      cmd_t       ec;
      ack_t       ea;
      logic [1:0] who;
      logic       outstanding;
      cur = '0;
      outstanding = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            outstanding = 1'b0;
         end else begin
            if (spi_start) begin
               check("start_overlap", 32'(outstanding), 32'd0);
               outstanding = 1'b1;
               if (cmd_q.size() == 0) begin
                  fail_now("unexpected_start");
               end else begin
                  ec  = cmd_q.pop_front();
                  cur = ec;
                  check("start_grant", 32'(grant), 32'(ec.who));
                  check("start_rnw", 32'(spi_rnw), 32'(ec.rnw));
                  check("start_addr", 32'(spi_addr), 32'(ec.addr));
                  check("start_wdata", 32'(spi_wdata), 32'(ec.wdata));
               end
            end
            if (adc_ack || dac_ack) begin
               who = {dac_ack, adc_ack};
               outstanding = 1'b0;
               if (ack_q.size() == 0) begin
                  fail_now("unexpected_ack");
               end else begin
                  ea = ack_q.pop_front();
                  check("ack_who", 32'(who), 32'(ea.who));
                  check("ack_rdata", 32'(ea.who[0] ? adc_rdata : dac_rdata), 32'(ea.rdata));
                  check("ack_err", 32'(ea.who[0] ? adc_err : dac_err), 32'(ea.err));
                  check("resp_grant", 32'(grant), 32'(ea.who));
                  check("resp_busy", 32'(busy), 32'd1);
                  check("resp_addr_stable", 32'(spi_addr), 32'(cur.addr));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] who, input logic req, input logic rnw,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (who[0]) begin
         adc_req = req; adc_rnw = rnw; adc_addr = addr; adc_wdata = wdata;
      end else begin
         dac_req = req; dac_rnw = rnw; dac_addr = addr; dac_wdata = wdata;
      end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (spi_start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) fail_now("start_timeout");
   endtask

   task automatic wait_ack(input int budget, output int cycles);
      cycles = 0;
      while (!(adc_ack || dac_ack) && cycles < budget) begin
         tick();
         cycles++;
      end
      if (!(adc_ack || dac_ack)) fail_now("ack_timeout");
   endtask

   // Done pulse lands d cycles after the ISSUE cycle (d=1: first WAIT cycle).
   task automatic spi_reply(input int d, input logic [DW-1:0] srd, input bit issue_done);
      if (issue_done) begin
         spi_done = 1'b1; spi_rdata = 8'hEE;
         tick();
         spi_done = 1'b0; spi_rdata = '0;
         repeat (d - 1) tick();
      end else begin
         repeat (d) tick();
      end
      spi_done = 1'b1; spi_rdata = srd;
      tick();
      spi_done = 1'b0; spi_rdata = '0;
   endtask

   task automatic do_txn(input logic [1:0] who, input logic rnw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int d, input logic [DW-1:0] srd,
                         input bit issue_done);
      bit ok;
      int c;
      cmd_q.push_back('{who: who, rnw: rnw, addr: addr, wdata: wdata});
      ack_q.push_back('{who: who, rdata: (rnw ? srd : 8'h00), err: 1'b0});
      set_req(who, 1'b1, rnw, addr, wdata);
      wait_start(ok);
      if (ok) begin
         spi_reply(d, srd, issue_done);
         wait_ack(4, c);
      end
      tick();
      set_req(who, 1'b0, rnw, addr, wdata);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin : stimulus
      bit   ok;
      int   c;
      cmd_t seq [4];
      logic [DW-1:0] srd [4];

      rst = 1'b1;
      adc_req = 0; adc_rnw = 0; adc_addr = '0; adc_wdata = '0;
      dac_req = 0; dac_rnw = 0; dac_addr = '0; dac_wdata = '0;
      spi_done = 0; spi_rdata = '0;
      repeat (3) tick();
      check("reset_ctrl", 32'({adc_ack, adc_err, dac_ack, dac_err, spi_start, grant, busy}), 32'd0);
      check("reset_data", 32'({adc_rdata, dac_rdata, spi_rnw}), 32'd0);
      check("reset_spi", 32'({spi_addr, spi_wdata}), 32'd0);
      rst = 1'b0;
      tick();

      // ADC write, done 10 cycles after start
      do_txn(2'b01, 1'b0, 13'h014, 8'hA5, 10, 8'h00, 1'b0);
      // DAC read
      do_txn(2'b10, 1'b1, 13'h01F, 8'h00, 4, 8'h3C, 1'b0);

      // Simultaneous requests after reset: ADC, DAC, ADC, DAC
      do_reset();
      seq[0] = '{who: 2'b01, rnw: 1'b0, addr: 13'h0A1, wdata: 8'h11};
      seq[1] = '{who: 2'b10, rnw: 1'b1, addr: 13'h0D1, wdata: 8'h00};
      seq[2] = '{who: 2'b01, rnw: 1'b1, addr: 13'h0A2, wdata: 8'h00};
      seq[3] = '{who: 2'b10, rnw: 1'b0, addr: 13'h0D2, wdata: 8'h22};
      srd[0] = 8'h00; srd[1] = 8'h5A; srd[2] = 8'hC3; srd[3] = 8'h00;
      for (int t = 0; t < 4; t++) begin
         cmd_q.push_back(seq[t]);
         ack_q.push_back('{who: seq[t].who, rdata: (seq[t].rnw ? srd[t] : 8'h00), err: 1'b0});
      end
      set_req(2'b01, 1'b1, seq[0].rnw, seq[0].addr, seq[0].wdata);
      set_req(2'b10, 1'b1, seq[1].rnw, seq[1].addr, seq[1].wdata);
      for (int t = 0; t < 4; t++) begin
         wait_start(ok);
         if (ok) begin
            spi_reply(2 + t, srd[t], 1'b0);
            wait_ack(4, c);
         end
         tick();
         if (t < 2)
            set_req(seq[t].who, 1'b1, seq[t+2].rnw, seq[t+2].addr, seq[t+2].wdata);
         else
            set_req(seq[t].who, 1'b0, seq[t].rnw, seq[t].addr, seq[t].wdata);
      end

      // Timeout: no done, ack 16 WAIT cycles after ISSUE with err=1
      cmd_q.push_back('{who: 2'b01, rnw: 1'b1, addr: 13'h100, wdata: 8'h00});
      ack_q.push_back('{who: 2'b01, rdata: 8'h00, err: 1'b1});
      set_req(2'b01, 1'b1, 1'b1, 13'h100, 8'h00);
      wait_start(ok);
      if (ok) begin
         wait_ack(40, c);
         check("timeout_latency", 32'(c), 32'(TO + 1));
      end
      tick();
      set_req(2'b01, 1'b0, 1'b1, 13'h100, 8'h00);
      do_txn(2'b10, 1'b1, 13'h0C4, 8'h00, 3, 8'h81, 1'b0);

      // Reset three cycles after start: everything clears, no ack
      cmd_q.push_back('{who: 2'b10, rnw: 1'b0, addr: 13'h0AA, wdata: 8'h55});
      set_req(2'b10, 1'b1, 1'b0, 13'h0AA, 8'h55);
      wait_start(ok);
      repeat (3) tick();
      rst = 1'b1;
      set_req(2'b10, 1'b0, 1'b0, 13'h0AA, 8'h55);
      tick();
      check("wreset_ctrl", 32'({adc_ack, adc_err, dac_ack, dac_err, spi_start, grant, busy}), 32'd0);
      check("wreset_data", 32'({adc_rdata, dac_rdata, spi_rnw}), 32'd0);
      check("wreset_spi", 32'({spi_addr, spi_wdata}), 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      spi_done = 1'b1; spi_rdata = 8'h66;
      tick();
      spi_done = 1'b0; spi_rdata = '0;
      repeat (5) tick();
      check("idle_after_late_done", 32'(busy), 32'd0);

      // Spurious done in IDLE, then done in ISSUE ignored
      spi_done = 1'b1; spi_rdata = 8'h77;
      tick();
      spi_done = 1'b0; spi_rdata = '0;
      check("idle_done_ignored", 32'(busy), 32'd0);
      do_txn(2'b10, 1'b1, 13'h1234, 8'h00, 5, 8'h12, 1'b1);

      // Done coincident with the timeout cycle: done wins
      do_txn(2'b01, 1'b1, 13'h1ABC, 8'h00, TO, 8'h9D, 1'b0);

      repeat (3) tick();
      check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
      check("ack_q_drained", 32'(ack_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
